// File: rtl/regfile.sv
// regfile: RV64 integer register file with per-register pending scoreboard; `REGFILE_BYPASS_EN enables same-cycle write-through
module regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_w_ena_i,
    input  logic [ADDR_W-1:0] rd_w_addr_i,
    input  logic [DATA_W-1:0] rd_w_data_i,
    input  logic              rs1_r_ena_i,
    input  logic [ADDR_W-1:0] rs1_r_addr_i,
    output logic [DATA_W-1:0] rs1_r_data_o,
    output logic              rs1_busy_o,
    input  logic              rs2_r_ena_i,
    input  logic [ADDR_W-1:0] rs2_r_addr_i,
    output logic [DATA_W-1:0] rs2_r_data_o,
    output logic              rs2_busy_o,
    input  logic              issue_ena_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              flush_i
);
    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [1:N-1];
    logic [N-1:1]      pending;
    logic [N-1:0]      pend;
    logic              wr, iss, byp1, byp2, clr1, clr2;

    assign wr   = rd_w_ena_i && rd_w_addr_i != '0;
    assign iss  = issue_ena_i && issue_addr_i != '0;
    assign pend = {pending, 1'b0};

`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr && rs1_r_addr_i == rd_w_addr_i;
    assign byp2 = wr && rs2_r_addr_i == rd_w_addr_i;
    assign clr1 = byp1 && !(issue_ena_i && issue_addr_i == rs1_r_addr_i);
    assign clr2 = byp2 && !(issue_ena_i && issue_addr_i == rs2_r_addr_i);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
`endif

    // register storage and scoreboard; a set issued this cycle overrides a retiring clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < N; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr) regs[rd_w_addr_i] <= rd_w_data_i;
            if (flush_i) pending <= '0;
            else begin
                if (wr) pending[rd_w_addr_i] <= 1'b0;
                if (iss) pending[issue_addr_i] <= 1'b1;
            end
        end
    end

    // port 1 read data and busy
    always_comb begin
        rs1_r_data_o = '0;
        rs1_busy_o   = 1'b0;
        if (rst && rs1_r_ena_i && rs1_r_addr_i != '0) begin
            rs1_r_data_o = byp1 ? rd_w_data_i : regs[rs1_r_addr_i];
            rs1_busy_o   = clr1 ? 1'b0 : pend[rs1_r_addr_i];
        end
    end

    // port 2 read data and busy
    always_comb begin
        rs2_r_data_o = '0;
        rs2_busy_o   = 1'b0;
        if (rst && rs2_r_ena_i && rs2_r_addr_i != '0) begin
            rs2_r_data_o = byp2 ? rd_w_data_i : regs[rs2_r_addr_i];
            rs2_busy_o   = clr2 ? 1'b0 : pend[rs2_r_addr_i];
        end
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed stimulus against an array model of the register file and scoreboard
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_w_ena_i;
    logic [4:0]  rd_w_addr_i;
    logic [63:0] rd_w_data_i;
    logic        rs1_r_ena_i, rs2_r_ena_i;
    logic [4:0]  rs1_r_addr_i, rs2_r_addr_i;
    logic [63:0] rs1_r_data_o, rs2_r_data_o;
    logic        rs1_busy_o, rs2_busy_o;
    logic        issue_ena_i;
    logic [4:0]  issue_addr_i;
    logic        flush_i;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    logic [63:0] m_regs [32];
    bit          m_pend [32];

    regfile #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .rd_w_ena_i(rd_w_ena_i), .rd_w_addr_i(rd_w_addr_i), .rd_w_data_i(rd_w_data_i),
        .rs1_r_ena_i(rs1_r_ena_i), .rs1_r_addr_i(rs1_r_addr_i),
        .rs1_r_data_o(rs1_r_data_o), .rs1_busy_o(rs1_busy_o),
        .rs2_r_ena_i(rs2_r_ena_i), .rs2_r_addr_i(rs2_r_addr_i),
        .rs2_r_data_o(rs2_r_data_o), .rs2_busy_o(rs2_busy_o),
        .issue_ena_i(issue_ena_i), .issue_addr_i(issue_addr_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_d(input logic e, input logic [4:0] a);
        if (!rst || !e || a == 0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (rd_w_ena_i && rd_w_addr_i == a) return rd_w_data_i;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_b(input logic e, input logic [4:0] a);
        if (!rst || !e || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rd_w_ena_i && rd_w_addr_i == a && !(issue_ena_i && issue_addr_i == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    // model state update from the rules: reset clears, writes land, flush beats issue, set beats clear
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 64'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (rd_w_ena_i && rd_w_addr_i != 0) m_regs[rd_w_addr_i] = rd_w_data_i;
            if (flush_i) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            else begin
                if (rd_w_ena_i) m_pend[rd_w_addr_i] = 1'b0;
                if (issue_ena_i) m_pend[issue_addr_i] = 1'b1;
                m_pend[0] = 1'b0;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("rs1_data", rs1_r_data_o, exp_d(rs1_r_ena_i, rs1_r_addr_i));
            chk("rs2_data", rs2_r_data_o, exp_d(rs2_r_ena_i, rs2_r_addr_i));
            chk("rs1_busy", {63'h0, rs1_busy_o}, {63'h0, exp_b(rs1_r_ena_i, rs1_r_addr_i)});
            chk("rs2_busy", {63'h0, rs2_busy_o}, {63'h0, exp_b(rs2_r_ena_i, rs2_r_addr_i)});
        end
    end

    task automatic idle();
        rd_w_ena_i = 0; rd_w_addr_i = 0; rd_w_data_i = 0;
        issue_ena_i = 0; issue_addr_i = 0; flush_i = 0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_r_ena_i = 1; rs1_r_addr_i = a1;
        rs2_r_ena_i = 1; rs2_r_addr_i = a2;
    endtask

    task automatic wrt(input logic [4:0] a, input logic [63:0] d);
        rd_w_ena_i = 1; rd_w_addr_i = a; rd_w_data_i = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_ena_i = 1; issue_addr_i = a;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        rs1_r_ena_i = 0; rs1_r_addr_i = 0; rs2_r_ena_i = 0; rs2_r_addr_i = 0;
        tick();
        started = 1;
        tick();
        rst = 1;
        rd(5, 5);
        settle();
        chk("post_reset_data", rs1_r_data_o, 64'h0);
        chk("post_reset_busy", {63'h0, rs1_busy_o}, 64'h0);

        wrt(5, 64'h1234);
        tick();
        settle();
        chk("x5_written", rs1_r_data_o, 64'h1234);
        rst = 0;
        issue(6);
        wrt(8, 64'h99);
        tick();
        rst = 0;
        rd(5, 6);
        settle();
        chk("in_reset_data", rs1_r_data_o, 64'h0);
        chk("in_reset_busy", {63'h0, rs2_busy_o}, 64'h0);
        tick();
        rst = 1;
        settle();
        chk("x5_cleared", rs1_r_data_o, 64'h0);
        chk("x6_issue_ignored", {63'h0, rs2_busy_o}, 64'h0);

        wrt(7, 64'hDEAD_BEEF_0000_0001);
        rd(8, 8);
        tick();
        settle();
        chk("x8_write_ignored", rs1_r_data_o, 64'h0);
        rd(7, 7);
        settle();
        chk("x7_rs1", rs1_r_data_o, 64'hDEAD_BEEF_0000_0001);
        chk("x7_rs2", rs2_r_data_o, 64'hDEAD_BEEF_0000_0001);
        wrt(0, 64'hFF);
        tick();
        rd(0, 0);
        settle();
        chk("x0_rs1", rs1_r_data_o, 64'h0);
        chk("x0_rs2", rs2_r_data_o, 64'h0);

        rd(1, 3);
        issue(3);
        tick();
        settle();
        chk("x3_busy", {63'h0, rs2_busy_o}, 64'h1);
        tick();
        tick();
        wrt(3, 64'h33);
        tick();
        settle();
        chk("x3_cleared", {63'h0, rs2_busy_o}, 64'h0);
        chk("x3_data", rs2_r_data_o, 64'h33);
        issue(3);
        wrt(3, 64'h34);
        tick();
        settle();
        chk("x3_set_wins", {63'h0, rs2_busy_o}, 64'h1);
        wrt(3, 64'h35);
        tick();

        issue(4);
        tick();
        issue(9);
        rd(4, 9);
        tick();
        settle();
        chk("x4_busy", {63'h0, rs1_busy_o}, 64'h1);
        chk("x9_busy", {63'h0, rs2_busy_o}, 64'h1);
        flush_i = 1;
        tick();
        settle();
        chk("x4_flushed", {63'h0, rs1_busy_o}, 64'h0);
        chk("x9_flushed", {63'h0, rs2_busy_o}, 64'h0);
        issue(4);
        flush_i = 1;
        wrt(9, 64'h909);
        tick();
        settle();
        chk("x4_issue_flushed", {63'h0, rs1_busy_o}, 64'h0);
        chk("x9_write_on_flush", rs2_r_data_o, 64'h909);

        rd(10, 11);
        wrt(10, 64'h55);
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rs1_r_data_o, 64'h55);
`else
        chk("no_bypass_data", rs1_r_data_o, 64'h0);
`endif
        chk("bypass_busy", {63'h0, rs1_busy_o}, 64'h0);
        tick();
        issue(11);
        tick();
        wrt(11, 64'hB1);
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("bypass_clear", {63'h0, rs2_busy_o}, 64'h0);
`else
        chk("no_bypass_busy", {63'h0, rs2_busy_o}, 64'h1);
`endif
        tick();

        for (int i = 1; i < 32; i++) begin
            wrt(i[4:0], {32'hA5A5_0000 | i, 32'h0F0F_0000 + i * 3});
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], 5'(31 - i));
            if (i % 4 == 0) issue(5'(i + 1));
            if (i % 5 == 0) wrt(5'(i + 2), 64'h5000 + i);
            if (i % 7 == 3) flush_i = 1;
            tick();
        end
        flush_i = 1;
        tick();

        wrt(12, 64'hABC);
        tick();
        issue(12);
        rd(12, 12);
        tick();
        settle();
        chk("x12_busy", {63'h0, rs1_busy_o}, 64'h1);
        chk("x12_data", rs1_r_data_o, 64'hABC);
        rst = 0;
        settle();
        chk("x12_busy_in_reset", {63'h0, rs2_busy_o}, 64'h0);
        tick();
        rst = 1;
        settle();
        chk("x12_busy_after_reset", {63'h0, rs1_busy_o}, 64'h0);
        chk("x12_data_after_reset", rs2_r_data_o, 64'h0);
        rs1_r_ena_i = 0;
        issue(12);
        tick();
        settle();
        chk("rs1_disabled_busy", {63'h0, rs1_busy_o}, 64'h0);
        chk("rs2_enabled_busy", {63'h0, rs2_busy_o}, 64'h1);
        tick();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
